// File: rtl/gamma_ctemp_mc_if.sv
// Pixel stream, gain-load and LUT-write signals for gamma_ctemp_mc.
// The master side drives samples and control; the slave side is the corrector.
interface gamma_ctemp_mc_if #(
    parameter int NCH    = 3,
    parameter int DIN_W  = 10,
    parameter int DOUT_W = 16,
    parameter int GAIN_W = 4
);
    logic [NCH*DIN_W-1:0]  din;
    logic                  din_val;
    logic                  din_sof;
    logic                  bypass;
    logic [NCH*GAIN_W-1:0] ct_gain;
    logic                  ovp;
    logic                  lut_we;
    logic [DIN_W-1:0]      lut_addr;
    logic [DOUT_W-1:0]     lut_wdata;
    logic [NCH*DOUT_W-1:0] dout;
    logic                  dout_val;
    logic                  dout_sof;

    modport master (
        output din, din_val, din_sof, bypass, ct_gain, ovp,
               lut_we, lut_addr, lut_wdata,
        input  dout, dout_val, dout_sof
    );

    modport slave (
        input  din, din_val, din_sof, bypass, ct_gain, ovp,
               lut_we, lut_addr, lut_wdata,
        output dout, dout_val, dout_sof
    );
endinterface

// File: rtl/gamma_ctemp_mc.sv
// Multi-channel gamma LUT followed by a frame-synchronous colour-temperature gain.
// Three-stage pipeline: LUT read, register, multiply with saturation.
module gamma_ctemp_mc #(
    parameter int NCH       = 3,
    parameter int DIN_W     = 10,
    parameter int DOUT_W    = 16,
    parameter int GAIN_W    = 4,
    parameter int GAIN_FRAC = 3
) (
    input logic             clk,
    input logic             rst,
    gamma_ctemp_mc_if.slave bus
);
    localparam int PW = DOUT_W + GAIN_W;
    localparam logic [GAIN_W-1:0]     UNITY     = GAIN_W'(2 ** GAIN_FRAC);
    localparam logic [NCH*GAIN_W-1:0] UNITY_ALL = {NCH{UNITY}};

    logic [DOUT_W-1:0] lut_mem [2**DIN_W];

    logic [NCH*GAIN_W-1:0] active_gain_q, active_gain_d;
    logic [NCH*GAIN_W-1:0] pend_gain_q, pend_gain_d;
    logic                  pend_flag_q, pend_flag_d;

    logic                  s1_val_q, s1_val_d, s1_sof_q, s1_sof_d;
    logic [NCH*DOUT_W-1:0] s1_data_q, s1_data_d;
    logic [NCH*GAIN_W-1:0] s1_gain_q, s1_gain_d;
    logic                  s2_val_q, s2_val_d, s2_sof_q, s2_sof_d;
    logic [NCH*DOUT_W-1:0] s2_data_q, s2_data_d;
    logic [NCH*GAIN_W-1:0] s2_gain_q, s2_gain_d;
    logic                  dout_val_q, dout_val_d, dout_sof_q, dout_sof_d;
    logic [NCH*DOUT_W-1:0] dout_q, dout_d;

    logic          xfer;
    logic [PW-1:0] prod;
    logic [PW-1:0] shifted;

    // The LUT is never reset; non-blocking write keeps same-cycle reads on old data.
    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            lut_mem[bus.lut_addr] <= bus.lut_wdata;
        end
    end

    always_comb begin
        active_gain_d = active_gain_q;
        pend_gain_d   = pend_gain_q;
        pend_flag_d   = pend_flag_q;
        s1_data_d     = s1_data_q;
        s1_gain_d     = s1_gain_q;
        s2_data_d     = s2_data_q;
        s2_gain_d     = s2_gain_q;
        dout_d        = dout_q;
        prod          = '0;
        shifted       = '0;

        xfer          = bus.din_val & bus.din_sof & pend_flag_q;
        if (xfer) begin
            active_gain_d = pend_gain_q;
        end
        pend_flag_d   = bus.ovp | (pend_flag_q & ~xfer);
        if (bus.ovp) begin
            pend_gain_d = bus.ct_gain;
        end

        // Each sample carries its own gain so a frame switch never touches older samples.
        s1_val_d = bus.din_val;
        s1_sof_d = bus.din_val & bus.din_sof;
        if (bus.din_val) begin
            s1_gain_d = xfer ? pend_gain_q : active_gain_q;
            for (int k = 0; k < NCH; k++) begin
                if (bus.bypass) begin
                    s1_data_d[k*DOUT_W +: DOUT_W] =
                        DOUT_W'({bus.din[k*DIN_W +: DIN_W], {DOUT_W{1'b0}}} >> DIN_W);
                end else begin
                    s1_data_d[k*DOUT_W +: DOUT_W] = lut_mem[bus.din[k*DIN_W +: DIN_W]];
                end
            end
        end

        s2_val_d = s1_val_q;
        s2_sof_d = s1_sof_q;
        if (s1_val_q) begin
            s2_data_d = s1_data_q;
            s2_gain_d = s1_gain_q;
        end

        dout_val_d = s2_val_q;
        dout_sof_d = s2_sof_q;
        if (s2_val_q) begin
            for (int k = 0; k < NCH; k++) begin
                prod    = PW'(s2_data_q[k*DOUT_W +: DOUT_W]) * PW'(s2_gain_q[k*GAIN_W +: GAIN_W]);
                shifted = prod >> GAIN_FRAC;
                dout_d[k*DOUT_W +: DOUT_W] = (|shifted[PW-1:DOUT_W]) ? {DOUT_W{1'b1}}
                                                                     : shifted[DOUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_gain_q <= UNITY_ALL;
            pend_gain_q   <= UNITY_ALL;
            pend_flag_q   <= 1'b0;
            s1_val_q      <= 1'b0;
            s1_sof_q      <= 1'b0;
            s1_data_q     <= '0;
            s1_gain_q     <= UNITY_ALL;
            s2_val_q      <= 1'b0;
            s2_sof_q      <= 1'b0;
            s2_data_q     <= '0;
            s2_gain_q     <= UNITY_ALL;
            dout_val_q    <= 1'b0;
            dout_sof_q    <= 1'b0;
            dout_q        <= '0;
        end else begin
            active_gain_q <= active_gain_d;
            pend_gain_q   <= pend_gain_d;
            pend_flag_q   <= pend_flag_d;
            s1_val_q      <= s1_val_d;
            s1_sof_q      <= s1_sof_d;
            s1_data_q     <= s1_data_d;
            s1_gain_q     <= s1_gain_d;
            s2_val_q      <= s2_val_d;
            s2_sof_q      <= s2_sof_d;
            s2_data_q     <= s2_data_d;
            s2_gain_q     <= s2_gain_d;
            dout_val_q    <= dout_val_d;
            dout_sof_q    <= dout_sof_d;
            dout_q        <= dout_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_val = dout_val_q;
    assign bus.dout_sof = dout_sof_q;
endmodule

// File: tb/tb_gamma_ctemp_mc.sv
// Directed bench for gamma_ctemp_mc: a per-sample arithmetic model is checked every
// cycle, and literal expectations at key points pin the model itself.
module tb_gamma_ctemp_mc;
    localparam int NCH       = 3;
    localparam int DIN_W     = 10;
    localparam int DOUT_W    = 16;
    localparam int GAIN_W    = 4;
    localparam int GAIN_FRAC = 3;
    localparam int DMAX      = (1 << DOUT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gamma_ctemp_mc_if #(.NCH(NCH), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .GAIN_W(GAIN_W)) bus ();

    gamma_ctemp_mc #(
        .NCH(NCH), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int m_lut [2**DIN_W];
    int m_act [NCH];
    int m_pend [NCH];
    bit m_flag;
    bit armed = 1'b0;
    bit pv [2];
    bit ps [2];
    int pd [2][NCH];
    bit m_val;
    bit m_sof;
    int m_dout [NCH];
    int g, dv, lv, r;
    bit take;

    // Each accepted sample's final value is computed the moment it enters, then delayed.
    always @(posedge clk) begin
        if (rst) begin
            armed  = 1'b1;
            m_flag = 1'b0;
            m_val  = 1'b0;
            m_sof  = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                m_act[k]  = 1 << GAIN_FRAC;
                m_pend[k] = 1 << GAIN_FRAC;
                m_dout[k] = 0;
            end
            for (int j = 0; j < 2; j++) begin
                pv[j] = 1'b0;
                ps[j] = 1'b0;
            end
        end else begin
            m_val = pv[1];
            m_sof = ps[1];
            if (pv[1]) m_dout = pd[1];
            pv[1] = pv[0];
            ps[1] = ps[0];
            pd[1] = pd[0];
            pv[0] = bus.din_val;
            ps[0] = bus.din_val && bus.din_sof;
            if (bus.din_val) begin
                take = bus.din_sof && m_flag;
                for (int k = 0; k < NCH; k++) begin
                    g  = take ? m_pend[k] : m_act[k];
                    dv = int'(bus.din[k*DIN_W +: DIN_W]);
                    lv = bus.bypass ? (dv << (DOUT_W - DIN_W)) : m_lut[dv];
                    r  = (lv * g) >> GAIN_FRAC;
                    pd[0][k] = (r > DMAX) ? DMAX : r;
                end
                if (take) begin
                    m_act  = m_pend;
                    m_flag = 1'b0;
                end
            end
            if (bus.ovp) begin
                for (int k = 0; k < NCH; k++) m_pend[k] = int'(bus.ct_gain[k*GAIN_W +: GAIN_W]);
                m_flag = 1'b1;
            end
        end
        if (bus.lut_we) m_lut[bus.lut_addr] = int'(bus.lut_wdata);
    end

    logic [NCH*DOUT_W-1:0] m_packed;
    bit ok;
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < NCH; k++) m_packed[k*DOUT_W +: DOUT_W] = DOUT_W'(m_dout[k]);
            ok = (bus.dout_val === m_val) && (bus.dout_sof === m_sof) && (bus.dout === m_packed);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL model t=%0t: dout=%h val=%b sof=%b, expected dout=%h val=%b sof=%b",
                         $time, bus.dout, bus.dout_val, bus.dout_sof, m_packed, m_val, m_sof);
            end
        end
    end

    task automatic applyStimulus(input logic [DIN_W-1:0] d, input logic v, input logic s,
                                 input logic b);
        bus.din     = {NCH{d}};
        bus.din_val = v;
        bus.din_sof = s;
        bus.bypass  = b;
        @(negedge clk);
        bus.ovp     = 1'b0;
        bus.lut_we  = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [NCH*DOUT_W-1:0] exp_d,
                               input logic exp_v);
        n_cmp++;
        if (bus.dout !== exp_d || bus.dout_val !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: dout=%h val=%b, expected dout=%h val=%b",
                     name, bus.dout, bus.dout_val, exp_d, exp_v);
        end
    endtask

    task automatic loadGain(input logic [NCH*GAIN_W-1:0] gv);
        bus.ct_gain = gv;
        bus.ovp     = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_val   = 1'b0;
        bus.din_sof   = 1'b0;
        bus.bypass    = 1'b0;
        bus.ct_gain   = '0;
        bus.ovp       = 1'b0;
        bus.lut_we    = 1'b0;
        bus.lut_addr  = '0;
        bus.lut_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", '0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 2**DIN_W; i++) begin
            bus.lut_we    = 1'b1;
            bus.lut_addr  = DIN_W'(i);
            bus.lut_wdata = DOUT_W'(i << 6);
            applyStimulus('0, 1'b0, 1'b0, 1'b0);
        end

        applyStimulus(10'h200, 1'b1, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("identity_latency3", {3{16'h8000}}, 1'b1);

        loadGain({4'd0, 4'd4, 4'd15});
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus(10'h300, 1'b1, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("gain_sat_4_0", {16'h0000, 16'h6000, 16'hFFFF}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_when_idle", {16'h0000, 16'h6000, 16'hFFFF}, 1'b0);

        loadGain({4'd12, 4'd8, 4'd4});
        applyStimulus(10'h200, 1'b1, 1'b0, 1'b0);
        applyStimulus(10'h200, 1'b1, 1'b1, 1'b0);
        applyStimulus(10'h100, 1'b1, 1'b0, 1'b0);
        checkOutput("midframe_old_gain", {16'h0000, 16'h4000, 16'hF000}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("sof_new_gain", {16'hC000, 16'h8000, 16'h4000}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_sof_new_gain", {16'h6000, 16'h4000, 16'h2000}, 1'b1);

        loadGain({3{4'd8}});
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        loadGain({3{4'd4}});
        applyStimulus(10'h200, 1'b1, 1'b1, 1'b0);
        applyStimulus(10'h200, 1'b1, 1'b0, 1'b0);
        applyStimulus(10'h200, 1'b1, 1'b1, 1'b0);
        checkOutput("ovp_sof_prev_pending", {3{16'h8000}}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovp_sof_same_frame", {3{16'h8000}}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovp_sof_next_frame", {3{16'h4000}}, 1'b1);

        loadGain({3{4'd8}});
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        bus.lut_we    = 1'b1;
        bus.lut_addr  = 10'd5;
        bus.lut_wdata = 16'h1234;
        applyStimulus(10'd5, 1'b1, 1'b1, 1'b0);
        applyStimulus(10'd5, 1'b1, 1'b0, 1'b0);
        applyStimulus(10'h3FF, 1'b1, 1'b0, 1'b1);
        checkOutput("lut_write_old_data", {3{16'h0140}}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("lut_write_new_data", {3{16'h1234}}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("bypass_3ff", {3{16'hFFC0}}, 1'b1);

        loadGain({3{4'd4}});
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        loadGain({3{4'd2}});
        applyStimulus(10'h200, 1'b1, 1'b1, 1'b0);
        applyStimulus(10'h200, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("reset_flush", '0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_no_stale_val", '0, 1'b0);
        applyStimulus(10'h200, 1'b1, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_unity_gain", {3{16'h8000}}, 1'b1);
        applyStimulus('0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
